// File: rtl/exec_ctrl.sv
// rtl/exec_ctrl.sv - execute/write-back controller in front of a 4x16 register file
// EXEC_MUL_EN enables opcode 9 (16-cycle shift-add multiply); otherwise opcode 9 is illegal.
module exec_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_instr,
  output logic [1:0]  r_add1,
  output logic [1:0]  r_add2,
  input  logic [15:0] r_data1,
  input  logic [15:0] r_data2,
  output logic [1:0]  w_add,
  output logic        w_flag,
  output logic [15:0] w_data,
  output logic        flag_z,
  output logic        flag_c,
  output logic        illegal,
  output logic        busy
);

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t      state_q, state_d;
  logic [1:0]  w_add_q, w_add_d;
  logic        w_flag_q, w_flag_d;
  logic [15:0] w_data_q, w_data_d;
  logic        flag_z_q, flag_z_d;
  logic        flag_c_q, flag_c_d;
  logic        illegal_q, illegal_d;

  logic [3:0]  op;
  logic [1:0]  rd, rs1, rs2;
  logic [7:0]  imm8;
  logic [15:0] op_a, op_b, alu_res;
  logic [16:0] sum, diff;
  logic        accept, wr, upd_z, upd_c, c_new, bad, is_mul;

`ifdef EXEC_MUL_EN
  logic [15:0] mul_a_q, mul_a_d;
  logic [15:0] mul_b_q, mul_b_d;
  logic [15:0] mul_acc_q, mul_acc_d;
  logic [1:0]  mul_rd_q, mul_rd_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] mul_acc_nxt;
`endif

  assign op   = in_instr[15:12];
  assign rd   = in_instr[11:10];
  assign rs1  = in_instr[9:8];
  assign rs2  = in_instr[7:6];
  assign imm8 = in_instr[7:0];

  assign r_add1 = rs1;
  assign r_add2 = rs2;

  // Bypass the pending write-back so a dependent op can issue back-to-back.
  assign op_a = (w_flag_q && (w_add_q == rs1)) ? w_data_q : r_data1;
  assign op_b = (w_flag_q && (w_add_q == rs2)) ? w_data_q : r_data2;
  assign sum  = {1'b0, op_a} + {1'b0, op_b};
  assign diff = {1'b0, op_a} - {1'b0, op_b};

  assign in_ready = ~reset && (state_q == S_IDLE);
  assign accept   = in_valid && in_ready;

  assign w_add   = w_add_q;
  assign w_flag  = w_flag_q;
  assign w_data  = w_data_q;
  assign flag_z  = flag_z_q;
  assign flag_c  = flag_c_q;
  assign illegal = illegal_q;
`ifdef EXEC_MUL_EN
  assign busy = (state_q == S_MUL);
`else
  assign busy = 1'b0;
`endif

  always_comb begin
    alu_res = 16'h0000;
    wr      = 1'b0;
    upd_z   = 1'b0;
    upd_c   = 1'b0;
    c_new   = 1'b0;
    bad     = 1'b0;
    is_mul  = 1'b0;
    case (op)
      4'd0: ;
      4'd1: begin alu_res = sum[15:0];  wr = 1'b1; upd_z = 1'b1; upd_c = 1'b1; c_new = sum[16];  end
      4'd2: begin alu_res = diff[15:0]; wr = 1'b1; upd_z = 1'b1; upd_c = 1'b1; c_new = diff[16]; end
      4'd3: begin alu_res = op_a & op_b; wr = 1'b1; upd_z = 1'b1; end
      4'd4: begin alu_res = op_a | op_b; wr = 1'b1; upd_z = 1'b1; end
      4'd5: begin alu_res = op_a ^ op_b; wr = 1'b1; upd_z = 1'b1; end
      4'd6: begin alu_res = {8'h00, imm8}; wr = 1'b1; end
      4'd7: begin alu_res = op_a << op_b[3:0]; wr = 1'b1; upd_z = 1'b1; end
      4'd8: begin alu_res = op_a >> op_b[3:0]; wr = 1'b1; upd_z = 1'b1; end
`ifdef EXEC_MUL_EN
      4'd9: is_mul = 1'b1;
`endif
      default: bad = 1'b1;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    w_add_d   = w_add_q;
    w_flag_d  = 1'b0;
    w_data_d  = w_data_q;
    flag_z_d  = flag_z_q;
    flag_c_d  = flag_c_q;
    illegal_d = 1'b0;
`ifdef EXEC_MUL_EN
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    mul_acc_d   = mul_acc_q;
    mul_rd_d    = mul_rd_q;
    cnt_d       = cnt_q;
    mul_acc_nxt = mul_acc_q + (mul_b_q[0] ? mul_a_q : 16'h0000);
`endif

    if (state_q == S_IDLE && accept) begin
      if (is_mul) begin
`ifdef EXEC_MUL_EN
        state_d   = S_MUL;
        mul_a_d   = op_a;
        mul_b_d   = op_b;
        mul_acc_d = 16'h0000;
        mul_rd_d  = rd;
        cnt_d     = 4'd0;
`endif
      end else begin
        if (wr) begin
          w_flag_d = 1'b1;
          w_add_d  = rd;
          w_data_d = alu_res;
        end
        if (upd_z) flag_z_d = (alu_res == 16'h0000);
        if (upd_c) flag_c_d = c_new;
        illegal_d = bad;
      end
    end

`ifdef EXEC_MUL_EN
    // One multiplier bit per cycle; the 16th step goes straight into the WB register.
    if (state_q == S_MUL) begin
      mul_acc_d = mul_acc_nxt;
      mul_a_d   = mul_a_q << 1;
      mul_b_d   = mul_b_q >> 1;
      cnt_d     = cnt_q + 4'd1;
      if (cnt_q == 4'd15) begin
        state_d  = S_IDLE;
        w_flag_d = 1'b1;
        w_add_d  = mul_rd_q;
        w_data_d = mul_acc_nxt;
        flag_z_d = (mul_acc_nxt == 16'h0000);
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      w_add_q   <= 2'd0;
      w_flag_q  <= 1'b0;
      w_data_q  <= 16'h0000;
      flag_z_q  <= 1'b0;
      flag_c_q  <= 1'b0;
      illegal_q <= 1'b0;
`ifdef EXEC_MUL_EN
      mul_a_q   <= 16'h0000;
      mul_b_q   <= 16'h0000;
      mul_acc_q <= 16'h0000;
      mul_rd_q  <= 2'd0;
      cnt_q     <= 4'd0;
`endif
    end else begin
      state_q   <= state_d;
      w_add_q   <= w_add_d;
      w_flag_q  <= w_flag_d;
      w_data_q  <= w_data_d;
      flag_z_q  <= flag_z_d;
      flag_c_q  <= flag_c_d;
      illegal_q <= illegal_d;
`ifdef EXEC_MUL_EN
      mul_a_q   <= mul_a_d;
      mul_b_q   <= mul_b_d;
      mul_acc_q <= mul_acc_d;
      mul_rd_q  <= mul_rd_d;
      cnt_q     <= cnt_d;
`endif
    end
  end

endmodule
